hi14a_pause_detect: RTL
=======================

HI14A_PAUSE_DETECT -- requirements
Module: hi14a_pause_detect

Interface
REQ-001 SHALL have parameter CARRIER_MIN, default 8'd40: minimum sample value counted as carrier present.
REQ-002 SHALL have parameter LOSS_SAMPLES, default 128: consecutive sub-CARRIER_MIN samples that declare carrier lost.
REQ-003 SHALL have parameter DECAY_PERIOD, default 64: samples between 1-LSB peak decrements.
REQ-004 SHALL have port ck_1356meg, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port adc_d, input, 8: unsigned demodulated field amplitude sample.
REQ-007 SHALL have port sample_en, input, 1: one-cycle strobe, adc_d valid; logic advances only when high.
REQ-008 SHALL have port carrier, output, 1: high in CARRIER or PAUSE state.
REQ-009 SHALL have port pause, output, 1: high while in PAUSE state; feeds hi_iso14443a reader-modulation input.
REQ-010 SHALL have port pause_start, output, 1: one-cycle strobe on CARRIER->PAUSE.
REQ-011 SHALL have port pause_len, output, 8: pause length in samples, saturating at 255, held until next update.
REQ-012 SHALL have port len_valid, output, 1: one-cycle strobe when pause_len updates.
REQ-013 SHALL have port peak, output, 8: tracked carrier amplitude.
REQ-014 SHALL have port lost, output, 1: one-cycle strobe on carrier loss.

Function
REQ-015 SHALL implement states IDLE, CARRIER, PAUSE; outputs registered, updated the cycle after the sample_en cycle.
REQ-016 SHALL, when sample_en low, hold all state, counters and outputs; strobes SHALL last exactly one cycle.
REQ-017 SHALL in IDLE move to CARRIER on a sample >= CARRIER_MIN and load peak with that sample.
REQ-018 SHALL in CARRIER set peak=adc_d when adc_d > peak, else decrement peak by 1 every DECAY_PERIOD samples, never below CARRIER_MIN.
REQ-019 SHALL compute thresholds from peak: low_th = peak>>1, high_th = (peak>>1)+(peak>>3), 8-bit, no overflow possible.
REQ-020 SHALL enter PAUSE from CARRIER when adc_d < low_th for the debounce count of consecutive samples (see Configuration); assert pause_start; clear length counter to the debounce count.
REQ-021 SHALL freeze peak and decay counter in PAUSE.
REQ-022 SHALL in PAUSE increment length counter per sample, saturating at 255.
REQ-023 SHALL exit PAUSE to CARRIER on adc_d >= high_th; same cycle load pause_len with counter and pulse len_valid.
REQ-024 SHALL samples between low_th and high_th in PAUSE count as pause (hysteresis).
REQ-025 SHALL, in CARRIER or PAUSE, count consecutive samples < CARRIER_MIN; on reaching LOSS_SAMPLES go to IDLE, pulse lost, clear peak, no len_valid.
REQ-026 SHALL give carrier loss priority over pause exit/entry on the same sample.
REQ-027 SHALL reset debounce count on any sample >= low_th in CARRIER.

Reset
REQ-028 SHALL on reset go to IDLE asynchronously; carrier, pause, pause_start, len_valid, lost = 0; pause_len = 0; peak = 0; all counters = 0.
REQ-029 SHALL, if reset asserted mid-pause, produce no len_valid or lost on release.

Configuration
REQ-030 SHALL, with macro HI14A_PAUSE_DEBOUNCE_EN defined, require 2 consecutive sub-low_th samples to enter PAUSE (length counter starts at 2).
REQ-031 SHALL, without HI14A_PAUSE_DEBOUNCE_EN, enter PAUSE on first sub-low_th sample (length counter starts at 1); all else identical.

Verification
REQ-032 SHALL cover: sample_en every 4 clocks, adc_d=200 x10, 0 x20, 200 -> carrier=1, peak=200, pause_start once, pause_len=20, len_valid once.
REQ-033 SHALL cover hysteresis: peak=200, adc_d 90 x5 then 110 x3 then 130 -> PAUSE entered, 110 counted, pause_len=8, exit on 130 (high_th=125).
REQ-034 SHALL cover debounce: peak=200, single sample 50 between 200s -> with macro no pause_start; without macro pause_start and pause_len=1.
REQ-035 SHALL cover loss: after carrier, adc_d=0 x128 -> lost pulse on 128th sample, state IDLE, peak=0, no len_valid.
REQ-036 SHALL cover saturation and decay: pause of 300 samples at adc_d=45 (>=CARRIER_MIN, <low_th) -> pause_len=255; carrier at 200 then 150 x640 -> peak=190.
REQ-037 SHALL cover reset mid-pause: assert reset during PAUSE -> all outputs 0 immediately, no strobes after release.

Source files
------------

// File: rtl/hi14a_pause_detect.sv
// rtl/hi14a_pause_detect.sv - ISO14443A reader pause detector with carrier tracking.
// Optional HI14A_PAUSE_DEBOUNCE_EN: two consecutive low samples required to enter PAUSE.
module hi14a_pause_detect #(
  parameter logic [7:0] CARRIER_MIN  = 8'd40,
  parameter int         LOSS_SAMPLES = 128,
  parameter int         DECAY_PERIOD = 64
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic [7:0] adc_d,
  input  logic       sample_en,
  output logic       carrier,
  output logic       pause,
  output logic       pause_start,
  output logic [7:0] pause_len,
  output logic       len_valid,
  output logic [7:0] peak,
  output logic       lost
);

  localparam int LW = $clog2(LOSS_SAMPLES + 1);
  localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

`ifdef HI14A_PAUSE_DEBOUNCE_EN
  localparam logic [1:0] DEB = 2'd2;
`else
  localparam logic [1:0] DEB = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, CARRIER, PAUSE} state_t;

  state_t          state, state_n;
  logic [7:0]      peak_n, len_cnt, len_n, plen_n;
  logic [DW-1:0]   decay_cnt, decay_n;
  logic [LW-1:0]   loss_cnt, loss_n;
  logic [1:0]      deb_cnt, deb_n;
  logic            start_n, valid_n, lost_n;
  logic [7:0]      low_th, high_th;
  logic            below_min, loss_hit;

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      peak        <= 8'd0;
      decay_cnt   <= '0;
      loss_cnt    <= '0;
      deb_cnt     <= 2'd0;
      len_cnt     <= 8'd0;
      pause_len   <= 8'd0;
      pause_start <= 1'b0;
      len_valid   <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_n;
      peak        <= peak_n;
      decay_cnt   <= decay_n;
      loss_cnt    <= loss_n;
      deb_cnt     <= deb_n;
      len_cnt     <= len_n;
      pause_len   <= plen_n;
      pause_start <= start_n;
      len_valid   <= valid_n;
      lost        <= lost_n;
    end
  end

  assign carrier = (state != IDLE);
  assign pause   = (state == PAUSE);

  // peak>>1 + peak>>3 peaks at 127+31, so 8 bits always suffice
  assign low_th    = {1'b0, peak[7:1]};
  assign high_th   = {1'b0, peak[7:1]} + {3'b000, peak[7:3]};
  assign below_min = (adc_d < CARRIER_MIN);
  assign loss_hit  = below_min && (loss_cnt == LW'(LOSS_SAMPLES - 1));

  always_comb begin
    state_n = state;
    peak_n  = peak;
    decay_n = decay_cnt;
    loss_n  = loss_cnt;
    deb_n   = deb_cnt;
    len_n   = len_cnt;
    plen_n  = pause_len;
    start_n = 1'b0;
    valid_n = 1'b0;
    lost_n  = 1'b0;
    if (sample_en) begin
      case (state)
        IDLE: begin
          if (!below_min) begin
            state_n = CARRIER;
            peak_n  = adc_d;
            decay_n = '0;
            loss_n  = '0;
            deb_n   = 2'd0;
          end
        end
        CARRIER, PAUSE: begin
          loss_n = below_min ? loss_cnt + LW'(1) : '0;
          if (loss_hit) begin
            // loss wins over any pause entry/exit on the same sample
            state_n = IDLE;
            lost_n  = 1'b1;
            peak_n  = 8'd0;
            decay_n = '0;
            loss_n  = '0;
            deb_n   = 2'd0;
            len_n   = 8'd0;
          end else if (state == CARRIER) begin
            if (adc_d > peak) begin
              peak_n  = adc_d;
              decay_n = '0;
            end else if (decay_cnt == DW'(DECAY_PERIOD - 1)) begin
              decay_n = '0;
              if (peak > CARRIER_MIN) peak_n = peak - 8'd1;
            end else begin
              decay_n = decay_cnt + DW'(1);
            end
            if (adc_d < low_th) begin
              if (deb_cnt == DEB - 2'd1) begin
                state_n = PAUSE;
                start_n = 1'b1;
                len_n   = {6'd0, DEB};
                deb_n   = 2'd0;
              end else begin
                deb_n = deb_cnt + 2'd1;
              end
            end else begin
              deb_n = 2'd0;
            end
          end else begin
            if (adc_d >= high_th) begin
              state_n = CARRIER;
              plen_n  = len_cnt;
              valid_n = 1'b1;
              len_n   = 8'd0;
            end else if (len_cnt != 8'hff) begin
              len_n = len_cnt + 8'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
